// File: rtl/vx_amo_sequencer_pkg.sv
// Shared definitions for the AMO sequencer slice.
//   - AMO opcode width and INST_AMO_* encodings (RISC-V funct5 values)
//   - sequencer state encoding (plain 3-bit constants)
//   - amo_compute(): the read-modify-write function shared by the ALU unit and the
//     optional write-skip compare
// Configuration macro: AMO_SKIP_WR_EN (consumed by vx_amo_sequencer).
package vx_amo_sequencer_pkg;

  localparam int unsigned AMO_OP_BITS = 5;

  localparam logic [AMO_OP_BITS-1:0] INST_AMO_ADD  = 5'h00;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_SWAP = 5'h01;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_XOR  = 5'h04;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_OR   = 5'h08;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_AND  = 5'h0C;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_MIN  = 5'h10;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_MAX  = 5'h14;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_MINU = 5'h18;
  localparam logic [AMO_OP_BITS-1:0] INST_AMO_MAXU = 5'h1C;

  typedef logic [2:0] amo_state_t;

  localparam amo_state_t StIdle   = 3'd0;
  localparam amo_state_t StRdReq  = 3'd1;
  localparam amo_state_t StRdWait = 3'd2;
  localparam amo_state_t StAlu    = 3'd3;
  localparam amo_state_t StWrReq  = 3'd4;
  localparam amo_state_t StRsp    = 3'd5;

  // in1 = old memory value, in2 = rs2. Unknown opcodes yield 0.
  function automatic logic [31:0] amo_compute(input logic [AMO_OP_BITS-1:0] op,
                                               input logic [31:0] in1,
                                               input logic [31:0] in2);
    logic [31:0] res;
    res = '0;
    case (op)
      INST_AMO_ADD:  res = in1 + in2;
      INST_AMO_SWAP: res = in2;
      INST_AMO_XOR:  res = in1 ^ in2;
      INST_AMO_OR:   res = in1 | in2;
      INST_AMO_AND:  res = in1 & in2;
      INST_AMO_MIN:  res = ($signed(in1) < $signed(in2)) ? in1 : in2;
      INST_AMO_MAX:  res = ($signed(in1) > $signed(in2)) ? in1 : in2;
      INST_AMO_MINU: res = (in1 < in2) ? in1 : in2;
      INST_AMO_MAXU: res = (in1 > in2) ? in1 : in2;
      default:       res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/vx_amo_sequencer_alu.sv
// AMO ALU unit: computes the atomic result and registers it, so the result is valid
// the cycle after 'en' is high.
// Ports:
//   clk, reset   clock, synchronous active-high reset (clears the result register)
//   en           capture a new result this cycle
//   op           INST_AMO_* opcode
//   in1, in2     old memory value, rs2 operand
//   result       registered ALU result
module vx_amo_sequencer_alu
  import vx_amo_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [AMO_OP_BITS-1:0] op,
  input  logic [31:0]            in1,
  input  logic [31:0]            in2,
  output logic [31:0]            result
);

  logic [31:0] result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q <= '0;
    end else if (en) begin
      result_q <= amo_compute(op, in1, in2);
    end
  end

  assign result = result_q;

endmodule

// File: rtl/vx_amo_sequencer.sv
// AMO sequencer: round-robin arbitration of NUM_REQS atomic requesters, then a single
// read-modify-write on the shared memory port, returning the old memory value.
// One AMO in flight; flow IDLE -> RD_REQ -> RD_WAIT -> ALU -> WR_REQ -> RSP -> IDLE.
// Configuration: define AMO_SKIP_WR_EN to skip the write when the ALU result equals the
// old value (ALU -> RSP directly).
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   req_valid/req_ready            per-requester handshake, req_ready one-hot (IDLE only)
//   req_op/addr/data/tag           packed per-requester fields
//   mem_req_valid/rw/addr/data     memory request (rw: 0 read, 1 write), mem_req_ready accept
//   mem_rsp_valid/data             read data return (only honoured in RD_WAIT)
//   rsp_valid/ready/data/idx/tag   completion carrying the old value, requester index and tag
module vx_amo_sequencer
  import vx_amo_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REQS = 4,
  parameter int unsigned ADDRW    = 32,
  parameter int unsigned TAGW     = 8,
  parameter int unsigned REQ_IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQS-1:0]           req_valid,
  output logic [NUM_REQS-1:0]           req_ready,
  input  logic [NUM_REQS*AMO_OP_BITS-1:0] req_op,
  input  logic [NUM_REQS*ADDRW-1:0]     req_addr,
  input  logic [NUM_REQS*32-1:0]        req_data,
  input  logic [NUM_REQS*TAGW-1:0]      req_tag,
  output logic                          mem_req_valid,
  output logic                          mem_req_rw,
  output logic [ADDRW-1:0]              mem_req_addr,
  output logic [31:0]                   mem_req_data,
  input  logic                          mem_req_ready,
  input  logic                          mem_rsp_valid,
  input  logic [31:0]                   mem_rsp_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_data,
  output logic [REQ_IDXW-1:0]           rsp_idx,
  output logic [TAGW-1:0]               rsp_tag
);

  localparam logic [REQ_IDXW-1:0] LastIdx = REQ_IDXW'(NUM_REQS - 1);
  localparam logic [REQ_IDXW:0]   NumReqsW = (REQ_IDXW + 1)'(NUM_REQS);

  amo_state_t               state_q, state_d;
  logic [REQ_IDXW-1:0]      rr_q, rr_d;
  logic [AMO_OP_BITS-1:0]   op_q, op_d;
  logic [ADDRW-1:0]         addr_q, addr_d;
  logic [31:0]              data_q, data_d;
  logic [TAGW-1:0]          tag_q, tag_d;
  logic [REQ_IDXW-1:0]      idx_q, idx_d;
  logic [31:0]              old_q, old_d;
  logic [31:0]              alu_result;

  // Round-robin pick: first valid requester at or after rr_q, wrapping.
  logic                     grant_found;
  logic [REQ_IDXW-1:0]      grant_idx;
  logic [NUM_REQS-1:0]      grant_oh;
  logic [REQ_IDXW:0]        cand;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = {1'b0, rr_q} + (REQ_IDXW + 1)'(i);
      if (cand >= NumReqsW) cand = cand - NumReqsW;
      if (!grant_found && req_valid[cand[REQ_IDXW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[REQ_IDXW-1:0];
      end
    end
    grant_oh[grant_idx] = grant_found;
  end

`ifdef AMO_SKIP_WR_EN
  // Decided in the ALU cycle from the combinational value, since the unit's output is
  // only registered at the end of that cycle.
  logic alu_unchanged;
  assign alu_unchanged = (amo_compute(op_q, old_q, data_q) == old_q);
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tag_d   = tag_q;
    idx_d   = idx_q;
    old_d   = old_q;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          op_d    = req_op[grant_idx*AMO_OP_BITS +: AMO_OP_BITS];
          addr_d  = req_addr[grant_idx*ADDRW +: ADDRW];
          data_d  = req_data[grant_idx*32 +: 32];
          tag_d   = req_tag[grant_idx*TAGW +: TAGW];
          idx_d   = grant_idx;
          rr_d    = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
          state_d = StRdReq;
        end
      end
      StRdReq: begin
        if (mem_req_ready) state_d = StRdWait;
      end
      StRdWait: begin
        if (mem_rsp_valid) begin
          old_d   = mem_rsp_data;
          state_d = StAlu;
        end
      end
      StAlu: begin
`ifdef AMO_SKIP_WR_EN
        state_d = alu_unchanged ? StRsp : StWrReq;
`else
        state_d = StWrReq;
`endif
      end
      StWrReq: begin
        if (mem_req_ready) state_d = StRsp;
      end
      StRsp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      idx_q   <= idx_d;
      old_q   <= old_d;
    end
  end

  vx_amo_sequencer_alu u_alu (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == StAlu),
    .op     (op_q),
    .in1    (old_q),
    .in2    (data_q),
    .result (alu_result)
  );

  // Handshake outputs are masked by reset so an in-flight AMO is dropped at once.
  assign req_ready     = (!reset && state_q == StIdle) ? grant_oh : '0;
  assign mem_req_valid = !reset && (state_q == StRdReq || state_q == StWrReq);
  assign mem_req_rw    = (state_q == StWrReq);
  assign mem_req_addr  = addr_q;
  assign mem_req_data  = alu_result;
  assign rsp_valid     = !reset && (state_q == StRsp);
  assign rsp_data      = old_q;
  assign rsp_idx       = idx_q;
  assign rsp_tag       = tag_q;

endmodule

// File: tb/tb_vx_amo_sequencer.sv
module tb_vx_amo_sequencer;
  import vx_amo_sequencer_pkg::*;

  localparam int unsigned NUM_REQS = 4;
  localparam int unsigned ADDRW    = 32;
  localparam int unsigned TAGW     = 8;
  localparam int unsigned IDXW     = 2;
`ifdef AMO_SKIP_WR_EN
  localparam bit SKIP_WR = 1'b1;
`else
  localparam bit SKIP_WR = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQS-1:0]     req_valid;
  logic [NUM_REQS-1:0]     req_ready;
  logic [NUM_REQS*5-1:0]   req_op;
  logic [NUM_REQS*32-1:0]  req_addr;
  logic [NUM_REQS*32-1:0]  req_data;
  logic [NUM_REQS*8-1:0]   req_tag;
  logic                    mem_req_valid, mem_req_rw;
  logic [31:0]             mem_req_addr, mem_req_data;
  logic                    mr_ready;
  logic                    mem_rsp_valid;
  logic [31:0]             mem_rsp_data;
  logic                    rsp_valid, rsp_ready;
  logic [31:0]             rsp_data;
  logic [IDXW-1:0]         rsp_idx;
  logic [7:0]              rsp_tag;

  always #5 clk = ~clk;

  vx_amo_sequencer #(
    .NUM_REQS (NUM_REQS),
    .ADDRW    (ADDRW),
    .TAGW     (TAGW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_tag       (req_tag),
    .mem_req_valid (mem_req_valid),
    .mem_req_rw    (mem_req_rw),
    .mem_req_addr  (mem_req_addr),
    .mem_req_data  (mem_req_data),
    .mem_req_ready (mr_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_idx       (rsp_idx),
    .rsp_tag       (rsp_tag)
  );

  int checks = 0;
  int failures = 0;

  // Memory model: 1-cycle read latency, writes posted; 'mute' swallows reads.
  logic [31:0] mem [logic [31:0]];
  logic        mute = 1'b0;
  logic        model_v = 1'b0;
  logic [31:0] model_d = '0;
  logic        stray_v = 1'b0;
  logic [31:0] stray_d = '0;
  assign mem_rsp_valid = model_v | stray_v;
  assign mem_rsp_data  = stray_v ? stray_d : model_d;

  always @(posedge clk) begin
    model_v <= 1'b0;
    if (mem_req_valid && mr_ready && !mem_req_rw && !mute) begin
      model_v <= 1'b1;
      model_d <= mem.exists(mem_req_addr) ? mem[mem_req_addr] : 32'h0;
    end
  end

  // Scoreboard queues: expected pushed at stimulus, actual captured by monitor.
  logic [63:0] wr_exp[$];
  logic [63:0] wr_act[$];
  logic [41:0] rsp_exp[$];
  logic [41:0] rsp_act[$];
  int          rd_cnt = 0;

  always @(negedge clk) begin
    if (mem_req_valid && mr_ready && mem_req_rw) wr_act.push_back({mem_req_addr, mem_req_data});
    if (mem_req_valid && mr_ready && !mem_req_rw) rd_cnt <= rd_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_act.push_back({rsp_idx, rsp_tag, rsp_data});
  end

  function automatic logic [31:0] amo_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'h00:   return a + b;
      5'h01:   return b;
      5'h04:   return a ^ b;
      5'h08:   return a | b;
      5'h0C:   return a & b;
      5'h10:   return ($signed(a) < $signed(b)) ? a : b;
      5'h14:   return ($signed(a) > $signed(b)) ? a : b;
      5'h18:   return (a < b) ? a : b;
      5'h1C:   return (a > b) ? a : b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [4:0] op, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [7:0] tag, input logic [31:0] old);
    mem[addr] = old;
    req_op[idx*5 +: 5]     = op;
    req_addr[idx*32 +: 32] = addr;
    req_data[idx*32 +: 32] = rs2;
    req_tag[idx*8 +: 8]    = tag;
    req_valid[idx]         = 1'b1;
  endtask

  task automatic expect_amo(input int idx, input logic [4:0] op, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [7:0] tag,
                            input logic [31:0] old);
    logic [31:0] res;
    res = amo_model(op, old, rs2);
    if (!(SKIP_WR && res == old)) wr_exp.push_back({addr, res});
    rsp_exp.push_back({2'(idx), tag, old});
  endtask

  // Waits for a grant, checks it is exactly requester idx, then drops that request.
  task automatic wait_grant(input int idx, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = 1'b1;
        check({tag, "_grant"}, 64'(req_ready), 64'(4'b0001 << idx));
      end
    end
    check({tag, "_grant_seen"}, 64'(got), 64'd1);
    step();
    req_valid[idx] = 1'b0;
  endtask

  task automatic finish_amo(input string tag);
    bit          got;
    logic [41:0] e, a;
    logic [63:0] we, wa;
    got = 1'b0;
    for (int n = 0; n < 80; n++) begin
      if (rsp_act.size() != 0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    if (got && rsp_exp.size() != 0) begin
      a = rsp_act.pop_front();
      e = rsp_exp.pop_front();
      check({tag, "_rsp_idx"},  64'(a[41:40]), 64'(e[41:40]));
      check({tag, "_rsp_tag"},  64'(a[39:32]), 64'(e[39:32]));
      check({tag, "_rsp_data"}, 64'(a[31:0]),  64'(e[31:0]));
    end
    check({tag, "_wr_count"}, 64'(wr_act.size()), 64'(wr_exp.size()));
    while (wr_exp.size() != 0 && wr_act.size() != 0) begin
      we = wr_exp.pop_front();
      wa = wr_act.pop_front();
      check({tag, "_wr_addr"}, 64'(wa[63:32]), 64'(we[63:32]));
      check({tag, "_wr_data"}, 64'(wa[31:0]),  64'(we[31:0]));
    end
    wr_exp.delete();
    wr_act.delete();
    rsp_exp.delete();
    rsp_act.delete();
  endtask

  task automatic amo(input int idx, input logic [4:0] op, input logic [31:0] addr,
                     input logic [31:0] rs2, input logic [7:0] tag, input logic [31:0] old,
                     input string name);
    step();
    issue(idx, op, addr, rs2, tag, old);
    expect_amo(idx, op, addr, rs2, tag, old);
    wait_grant(idx, name);
    finish_amo(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  seen;
    bit  bad;
    int  prev_rd;

    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_addr  = '0;
    req_data  = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    mr_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);

    // 1: AMOADD from requester 0, grant-to-response latency
    step();
    issue(0, INST_AMO_ADD, 32'h40, 32'd5, 8'hA5, 32'd10);
    expect_amo(0, INST_AMO_ADD, 32'h40, 32'd5, 8'hA5, 32'd10);
    wait_grant(0, "t1");
    lat  = 1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    check("t1_latency", 64'(seen ? lat : -1), 64'd5);
    finish_amo("t1");

    // 2: requesters 1..3 together with rr at 1, then wrap to 0
    step();
    for (int k = 1; k < 4; k++)
      issue(k, INST_AMO_ADD, 32'h100 * k, 32'(k), 8'(8'h10 + k), 32'h1000 * k);
    for (int k = 1; k < 4; k++) begin
      wait_grant(k, "t2");
      expect_amo(k, INST_AMO_ADD, 32'h100 * k, 32'(k), 8'(8'h10 + k), 32'h1000 * k);
      finish_amo("t2");
    end
    amo(0, INST_AMO_SWAP, 32'h500, 32'hAA, 8'h05, 32'h55, "t2_wrap");

    // 3: signed vs unsigned min
    amo(0, INST_AMO_MIN,  32'h60, 32'hFFFF_FFFF, 8'h31, 32'd1, "t3_min");
    amo(2, INST_AMO_MINU, 32'h64, 32'hFFFF_FFFF, 8'h32, 32'd1, "t3_minu");
    amo(1, INST_AMO_MAXU, 32'h68, 32'h8000_0000, 8'h33, 32'd7, "t3_maxu");
    amo(3, 5'h03, 32'h6C, 32'h1234, 8'h34, 32'd9, "t3_unknown");
    amo(0, INST_AMO_OR, 32'h70, 32'd0, 8'h35, 32'd7, "t3_or_same");

    // 4: memory stalls in RD_REQ and WR_REQ
    step();
    mr_ready = 1'b0;
    prev_rd  = rd_cnt;
    issue(1, INST_AMO_ADD, 32'h900, 32'd3, 8'h19, 32'd4);
    expect_amo(1, INST_AMO_ADD, 32'h900, 32'd3, 8'h19, 32'd4);
    wait_grant(1, "t4");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_rd_valid", 64'(mem_req_valid), 64'd1);
      check("t4_rd_rw", 64'(mem_req_rw), 64'd0);
      check("t4_rd_addr", 64'(mem_req_addr), 64'h900);
    end
    step();
    mr_ready = 1'b1;
    step();
    mr_ready = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_rw) seen = 1'b1;
    end
    check("t4_wr_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 3; k++) begin
      check("t4_wr_valid", 64'(mem_req_valid && mem_req_rw), 64'd1);
      check("t4_wr_data", 64'(mem_req_data), 64'd7);
      check("t4_wr_addr", 64'(mem_req_addr), 64'h900);
      if (k < 2) @(negedge clk);
    end
    step();
    mr_ready = 1'b1;
    finish_amo("t4");
    check("t4_reads", 64'(rd_cnt - prev_rd), 64'd1);

    // 5: response back-pressure with another requester waiting
    step();
    rsp_ready = 1'b0;
    issue(3, INST_AMO_XOR, 32'h300, 32'hF0F0, 8'h33, 32'h0FF0);
    expect_amo(3, INST_AMO_XOR, 32'h300, 32'hF0F0, 8'h33, 32'h0FF0);
    wait_grant(3, "t5");
    issue(2, INST_AMO_AND, 32'h200, 32'hFF00, 8'h22, 32'h1234);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("t5_rsp_seen", 64'(seen), 64'd1);
    for (int k = 0; k < 4; k++) begin
      check("t5_hold_valid", 64'(rsp_valid), 64'd1);
      check("t5_hold_data", 64'(rsp_data), 64'h0FF0);
      check("t5_hold_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    step();
    rsp_ready = 1'b1;
    finish_amo("t5a");
    wait_grant(2, "t5b");
    expect_amo(2, INST_AMO_AND, 32'h200, 32'hFF00, 8'h22, 32'h1234);
    finish_amo("t5b");

    // 6: reset while waiting for read data, stray read data afterwards
    step();
    mute = 1'b1;
    issue(0, INST_AMO_ADD, 32'h700, 32'd1, 8'h77, 32'h70);
    prev_rd = rd_cnt;
    wait_grant(0, "t6");
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (rd_cnt != prev_rd) seen = 1'b1;
    end
    check("t6_read_seen", 64'(seen), 64'd1);
    step();
    reset = 1'b1;
    step();
    step();
    reset   = 1'b0;
    stray_v = 1'b1;
    stray_d = 32'hDEAD;
    step();
    stray_v = 1'b0;
    mute    = 1'b0;
    bad     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bad = bad | mem_req_valid | rsp_valid | (req_ready != '0);
    end
    check("t6_quiet", 64'(bad), 64'd0);
    check("t6_addr", 64'(mem_req_addr), 64'd0);
    check("t6_wdata", 64'(mem_req_data), 64'd0);
    check("t6_rsp_data", 64'(rsp_data), 64'd0);
    check("t6_rsp_tag", 64'(rsp_tag), 64'd0);
    check("t6_writes", 64'(wr_act.size()), 64'd0);
    check("t6_rsps", 64'(rsp_act.size()), 64'd0);

    // rr pointer restarts at 0 after reset
    step();
    issue(1, INST_AMO_ADD, 32'hA0, 32'd2, 8'hB1, 32'd20);
    issue(0, INST_AMO_ADD, 32'hA4, 32'd3, 8'hB0, 32'd30);
    wait_grant(0, "t6_rr0");
    expect_amo(0, INST_AMO_ADD, 32'hA4, 32'd3, 8'hB0, 32'd30);
    finish_amo("t6_rr0");
    wait_grant(1, "t6_rr1");
    expect_amo(1, INST_AMO_ADD, 32'hA0, 32'd2, 8'hB1, 32'd20);
    finish_amo("t6_rr1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
